// File: rtl/rx_frame_sequencer.sv
// Groups UART bytes into 2-byte frames and commits four display nibbles per good frame.
// Bad frames show ERR_CODE on every digit; a missing second byte is dropped after a timeout.
module rx_frame_sequencer #(
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter int          TMR_W          = 20,
  parameter logic [3:0]  ERR_CODE       = 4'hB
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Rx_DATA,
  input  logic       Rx_VALID,
  input  logic       Rx_FERROR,
  input  logic       Rx_PERROR,
  input  logic       sclr,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic       frame_done,
  output logic       frame_err,
  output logic       timeout,
  output logic [7:0] err_count
);

  typedef enum logic {IDLE, WAIT2} state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [7:0]       byte0;
  logic             err_pend;
  logic             byte_bad;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign byte_bad = Rx_FERROR | Rx_PERROR;

  // First byte of a frame is pure data; a reset simply leaves it stale.
  always_ff @(posedge clk) begin
    if (!reset && !sclr && state == IDLE && Rx_VALID)
      byte0 <= Rx_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      err_pend   <= 1'b0;
      digit1     <= 4'h0;
      digit2     <= 4'h0;
      digit3     <= 4'h0;
      digit4     <= 4'h0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
      if (sclr) begin
        state    <= IDLE;
        timer    <= '0;
        err_pend <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (Rx_VALID) begin
              err_pend <= byte_bad;
              timer    <= '0;
              state    <= WAIT2;
            end
          end
          WAIT2: begin
            timer <= timer + TMR_W'(1);
            // A strobe on the expiry cycle still completes the frame.
            if (Rx_VALID) begin
              if (err_pend || byte_bad) begin
                digit1    <= ERR_CODE;
                digit2    <= ERR_CODE;
                digit3    <= ERR_CODE;
                digit4    <= ERR_CODE;
                frame_err <= 1'b1;
                err_count <= sat_inc(err_count);
              end else begin
                digit1     <= byte0[7:4];
                digit2     <= byte0[3:0];
                digit3     <= Rx_DATA[3:0];
                digit4     <= Rx_DATA[7:4];
                frame_done <= 1'b1;
              end
              err_pend <= 1'b0;
              state    <= IDLE;
            end else if (timer == TMR_LAST) begin
              timeout   <= 1'b1;
              err_count <= sat_inc(err_count);
              err_pend  <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Scoreboard bench for rx_frame_sequencer: expected frame events are queued as stimulus
// is driven and matched against pulses seen on the falling clock edge.
module tb_rx_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_FERROR;
  logic       Rx_PERROR;
  logic       sclr;
  logic [3:0] digit1, digit2, digit3, digit4;
  logic       frame_done, frame_err, timeout;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         kind;   // 0 done, 1 err, 2 timeout
    logic [15:0] dig;
    logic [7:0]  cnt;
  } ev_t;

  ev_t         q[$];
  logic [15:0] exp_dig = 16'h0000;
  logic [7:0]  exp_cnt = 8'h00;

  always #5 clk = ~clk;

  rx_frame_sequencer #(.TIMEOUT_CYCLES(16), .TMR_W(5), .ERR_CODE(4'hB)) dut (
    .clk(clk), .reset(reset), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID),
    .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR), .sclr(sclr),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .frame_done(frame_done), .frame_err(frame_err), .timeout(timeout),
    .err_count(err_count)
  );

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    int  n;
    int  k;
    ev_t e;
    n = int'(frame_done === 1'b1) + int'(frame_err === 1'b1) + int'(timeout === 1'b1);
    if (n > 0) begin
      checks++;
      k = (frame_done === 1'b1) ? 0 : (frame_err === 1'b1) ? 1 : 2;
      if (n > 1) begin
        failures++;
        $display("FAIL pulse_exclusive: done=%b err=%b timeout=%b, required one at a time",
                 frame_done, frame_err, timeout);
      end else if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: kind=%0d seen, required no pulse", k);
      end else begin
        e = q.pop_front();
        if (k != e.kind || {digit1, digit2, digit3, digit4} !== e.dig || err_count !== e.cnt) begin
          failures++;
          $display("FAIL event: kind=%0d digits=%h count=%h, required kind=%0d digits=%h count=%h",
                   k, {digit1, digit2, digit3, digit4}, err_count, e.kind, e.dig, e.cnt);
        end
      end
    end
  end

  function automatic logic [7:0] model_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic fe, input logic pe);
    @(negedge clk);
    Rx_DATA = d; Rx_FERROR = fe; Rx_PERROR = pe; Rx_VALID = 1'b1;
    @(negedge clk);
    Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
  endtask

  task automatic push_evt(input int kind, input logic [7:0] b0, input logic [7:0] b1);
    ev_t e;
    if (kind == 0) exp_dig = {b0[7:4], b0[3:0], b1[3:0], b1[7:4]};
    else if (kind == 1) exp_dig = 16'hBBBB;
    if (kind != 0) exp_cnt = model_inc(exp_cnt);
    e.kind = kind; e.dig = exp_dig; e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic frame(input logic [7:0] b0, input logic bad0,
                       input logic [7:0] b1, input logic bad1, input int gap);
    send_byte(b0, 1'b0, bad0);
    idle(gap);
    push_evt((bad0 || bad1) ? 1 : 0, b0, b1);
    send_byte(b1, bad1, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d events pending, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    checks++;
    if ({digit1, digit2, digit3, digit4} !== 16'h0000 || err_count !== 8'h00 ||
        {frame_done, frame_err, timeout} !== 3'b000) begin
      failures++;
      $display("FAIL reset_state: digits=%h count=%h pulses=%b, required 0000 00 000",
               {digit1, digit2, digit3, digit4}, err_count, {frame_done, frame_err, timeout});
    end
  endtask

  task automatic test_good_frame();
    frame(8'h12, 1'b0, 8'h34, 1'b0, 8);
    wait_drain("good");
    checks++;
    if ({digit1, digit2, digit3, digit4} !== 16'h1243 || err_count !== 8'h00) begin
      failures++;
      $display("FAIL good_frame: digits=%h count=%h, required 1243 00",
               {digit1, digit2, digit3, digit4}, err_count);
    end
  endtask

  task automatic test_bad_frame();
    frame(8'h56, 1'b1, 8'h78, 1'b0, 3);
    wait_drain("bad");
    checks++;
    if ({digit1, digit2, digit3, digit4} !== 16'hBBBB || err_count !== 8'h01) begin
      failures++;
      $display("FAIL bad_frame: digits=%h count=%h, required BBBB 01",
               {digit1, digit2, digit3, digit4}, err_count);
    end
  endtask

  task automatic test_timeout();
    int seen;
    seen = 0;
    send_byte(8'hAA, 1'b0, 1'b0);
    push_evt(2, 8'h00, 8'h00);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin seen = i; break; end
    end
    checks++;
    if (seen != 16) begin
      failures++;
      $display("FAIL timeout_cycle: pulse at cycle %0d, required 16", seen);
    end
    wait_drain("timeout");
    checks++;
    if ({digit1, digit2, digit3, digit4} !== 16'hBBBB || err_count !== 8'h02) begin
      failures++;
      $display("FAIL timeout_hold: digits=%h count=%h, required BBBB 02",
               {digit1, digit2, digit3, digit4}, err_count);
    end
    frame(8'h01, 1'b0, 8'h02, 1'b0, 2);
    wait_drain("after_timeout");
    checks++;
    if ({digit1, digit2, digit3, digit4} !== 16'h0120 || err_count !== 8'h02) begin
      failures++;
      $display("FAIL after_timeout: digits=%h count=%h, required 0120 02",
               {digit1, digit2, digit3, digit4}, err_count);
    end
  endtask

  task automatic test_expiry_race();
    send_byte(8'h11, 1'b0, 1'b0);
    idle(14);
    push_evt(0, 8'h11, 8'h99);
    send_byte(8'h99, 1'b0, 1'b0);
    idle(24);
    wait_drain("race");
    checks++;
    if ({digit1, digit2, digit3, digit4} !== 16'h1199 || err_count !== 8'h02) begin
      failures++;
      $display("FAIL expiry_race: digits=%h count=%h, required 1199 02",
               {digit1, digit2, digit3, digit4}, err_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      frame(8'(i), 1'b1, 8'(i + 1), 1'b0, 0);
    end
    wait_drain("sat");
    checks++;
    if (err_count !== 8'hFF || {digit1, digit2, digit3, digit4} !== 16'hBBBB) begin
      failures++;
      $display("FAIL saturate: count=%h digits=%h, required FF BBBB",
               err_count, {digit1, digit2, digit3, digit4});
    end
    frame(8'h5A, 1'b0, 8'hC3, 1'b0, 1);
    wait_drain("sat_good");
    checks++;
    if (err_count !== 8'hFF || {digit1, digit2, digit3, digit4} !== 16'h5A3C) begin
      failures++;
      $display("FAIL saturate_good: count=%h digits=%h, required FF 5A3C",
               err_count, {digit1, digit2, digit3, digit4});
    end
  endtask

  task automatic test_sclr_reset();
    logic [15:0] held;
    held = exp_dig;
    send_byte(8'h55, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    sclr = 1'b1; Rx_DATA = 8'h66; Rx_VALID = 1'b1;
    @(negedge clk);
    sclr = 1'b0; Rx_VALID = 1'b0;
    idle(20);
    checks++;
    if ({digit1, digit2, digit3, digit4} !== held || err_count !== 8'hFF) begin
      failures++;
      $display("FAIL sclr_hold: digits=%h count=%h, required %h FF",
               {digit1, digit2, digit3, digit4}, err_count, held);
    end
    frame(8'h21, 1'b0, 8'h43, 1'b0, 2);
    wait_drain("sclr");
    checks++;
    if ({digit1, digit2, digit3, digit4} !== 16'h2134 || err_count !== 8'hFF) begin
      failures++;
      $display("FAIL sclr_next: digits=%h count=%h, required 2134 FF",
               {digit1, digit2, digit3, digit4}, err_count);
    end
    send_byte(8'h77, 1'b1, 1'b0);
    idle(2);
    @(negedge clk);
    reset = 1'b1; Rx_DATA = 8'h88; Rx_VALID = 1'b1;
    @(negedge clk);
    reset = 1'b0; Rx_VALID = 1'b0;
    exp_dig = 16'h0000; exp_cnt = 8'h00;
    idle(20);
    checks++;
    if ({digit1, digit2, digit3, digit4} !== 16'h0000 || err_count !== 8'h00) begin
      failures++;
      $display("FAIL midframe_reset: digits=%h count=%h, required 0000 00",
               {digit1, digit2, digit3, digit4}, err_count);
    end
    frame(8'h87, 1'b0, 8'h65, 1'b0, 2);
    wait_drain("post_reset");
    checks++;
    if ({digit1, digit2, digit3, digit4} !== 16'h8756 || err_count !== 8'h00) begin
      failures++;
      $display("FAIL post_reset: digits=%h count=%h, required 8756 00",
               {digit1, digit2, digit3, digit4}, err_count);
    end
  endtask

  initial begin
    reset = 1'b1; sclr = 1'b0; Rx_DATA = 8'h00;
    Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_timeout();
    test_expiry_race();
    test_saturation();
    test_sclr_reset();
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "time limit");
  end

endmodule
